// File: rtl/huffman_pkg.sv
// huffman_pkg -- shared definitions for the huffman_rank histogram/ranking block.
// Holds the frame FSM state encoding and the default parameter constants
// used by huffman_rank and huffman_argmax.
package huffman_pkg;

  // Default configuration: six symbols, 8-bit samples, 100 samples per frame.
  localparam int DEF_NUM_SYM = 6;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TOTAL   = 100;
  localparam int DEF_CNT_W   = 8;

  // ACC collects samples into the histogram; SORT ranks the symbols.
  typedef enum logic [0:0] {
    ACC  = 1'b0,
    SORT = 1'b1
  } state_t;

  // Width of a symbol ID field (IDs run 1..n, so n itself must fit).
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/huffman_argmax.sv
// huffman_argmax -- combinational selection of the unpicked symbol with the
// largest count. Ties resolve toward the lowest symbol index because a later
// candidate only replaces the current best when strictly larger.
// Ports:
//   counts  in   NUM_SYM*CNT_W  count of symbol index k in slice k
//   picked  in   NUM_SYM        bit k set when symbol index k is already ranked
//   sel     out  IDX_W          zero-based index of the selected symbol
module huffman_argmax #(
  parameter int NUM_SYM = 6,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_SYM*CNT_W-1:0] counts,
  input  logic [NUM_SYM-1:0]       picked,
  output logic [IDX_W-1:0]         sel
);

  logic [CNT_W-1:0] best_s;
  logic             found_s;

  // Linear scan for the largest unpicked count, first occurrence wins.
  always_comb begin
    best_s  = '0;
    found_s = 1'b0;
    sel     = '0;
    for (int k = 0; k < NUM_SYM; k++) begin
      if (!picked[k] && (!found_s || (counts[k*CNT_W +: CNT_W] > best_s))) begin
        best_s  = counts[k*CNT_W +: CNT_W];
        sel     = IDX_W'(k);
        found_s = 1'b1;
      end else begin
        best_s  = best_s;
      end
    end
  end

endmodule

// File: rtl/huffman_rank.sv
// huffman_rank -- builds a per-frame histogram of symbols 1..NUM_SYM and then
// ranks the symbols by descending count (stable, lower ID first on ties).
// A frame closes on the TOTAL-th in-range sample; the following NUM_SYM cycles
// perform one selection per cycle, after which the block returns to collecting.
// Optional feature: define HUFF_OOR_CNT_EN to count (saturating) out-of-range
// samples seen while collecting; otherwise oor_cnt is tied to zero.
// Ports:
//   clk         in   1              clock, rising edge
//   reset       in   1              synchronous active-high reset
//   gray_valid  in   1              sample strobe
//   gray_data   in   DATA_W         symbol value
//   busy        out  1              samples ignored (not collecting)
//   CNT_valid   out  1              one-cycle pulse, cnt_flat holds a new histogram
//   cnt_flat    out  NUM_SYM*CNT_W  count of symbol k in slice k-1
//   sort_valid  out  1              one-cycle pulse, rank_flat is complete
//   rank_flat   out  NUM_SYM*IDX_W  rank r (0 = largest) holds symbol ID in slice r
//   oor_cnt     out  CNT_W          out-of-range sample count
module huffman_rank
  import huffman_pkg::*;
#(
  parameter int  NUM_SYM = DEF_NUM_SYM,
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  TOTAL   = DEF_TOTAL,
  parameter int  CNT_W   = DEF_CNT_W,
  localparam int IDX_W   = idx_width(NUM_SYM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     gray_valid,
  input  logic [DATA_W-1:0]        gray_data,
  output logic                     busy,
  output logic                     CNT_valid,
  output logic [NUM_SYM*CNT_W-1:0] cnt_flat,
  output logic                     sort_valid,
  output logic [NUM_SYM*IDX_W-1:0] rank_flat,
  output logic [CNT_W-1:0]         oor_cnt
);

  // A frame must be countable without wrapping any counter.
  if ((2 ** CNT_W) - 1 < TOTAL) begin : g_cnt_w_check
    $error("huffman_rank: CNT_W too narrow for TOTAL");
  end

  state_t                   state_r;
  logic [CNT_W-1:0]         counts_r [NUM_SYM];
  logic [CNT_W-1:0]         sample_cnt_r;
  logic [NUM_SYM-1:0]       picked_r;
  logic [IDX_W-1:0]         step_r;

  logic                     in_range_s;
  logic                     hit_s;
  logic                     last_s;
  logic [DATA_W-1:0]        sym_idx_s;
  logic [CNT_W-1:0]         cnt_inc_s [NUM_SYM];
  logic [NUM_SYM*CNT_W-1:0] counts_flat_s;
  logic [IDX_W-1:0]         pick_s;

  // Sample qualification and the histogram as it will be after this edge.
  always_comb begin
    in_range_s    = (gray_data >= DATA_W'(1)) && (gray_data <= DATA_W'(NUM_SYM));
    sym_idx_s     = gray_data - DATA_W'(1);
    hit_s         = gray_valid && in_range_s && (state_r == ACC);
    last_s        = hit_s && (sample_cnt_r == CNT_W'(TOTAL - 1));
    counts_flat_s = '0;
    for (int k = 0; k < NUM_SYM; k++) begin
      if (hit_s && (sym_idx_s == DATA_W'(k))) begin
        cnt_inc_s[k] = counts_r[k] + CNT_W'(1);
      end else begin
        cnt_inc_s[k] = counts_r[k];
      end
      counts_flat_s[k*CNT_W +: CNT_W] = counts_r[k];
    end
  end

  huffman_argmax #(
    .NUM_SYM (NUM_SYM),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_argmax (
    .counts (counts_flat_s),
    .picked (picked_r),
    .sel    (pick_s)
  );

  // Frame FSM: histogram accumulation, per-cycle ranking and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ACC;
      busy         <= 1'b0;
      CNT_valid    <= 1'b0;
      sort_valid   <= 1'b0;
      cnt_flat     <= '0;
      rank_flat    <= '0;
      sample_cnt_r <= '0;
      picked_r     <= '0;
      step_r       <= '0;
      for (int k = 0; k < NUM_SYM; k++) begin
        counts_r[k] <= '0;
      end
    end else begin
      CNT_valid  <= 1'b0;
      sort_valid <= 1'b0;
      case (state_r)
        ACC: begin
          if (hit_s) begin
            counts_r     <= cnt_inc_s;
            sample_cnt_r <= sample_cnt_r + CNT_W'(1);
          end
          if (last_s) begin
            // Publish the histogram including the closing sample.
            for (int k = 0; k < NUM_SYM; k++) begin
              cnt_flat[k*CNT_W +: CNT_W] <= cnt_inc_s[k];
            end
            CNT_valid <= 1'b1;
            busy      <= 1'b1;
            step_r    <= '0;
            state_r   <= SORT;
          end
        end
        SORT: begin
          for (int r = 0; r < NUM_SYM; r++) begin
            if (step_r == IDX_W'(r)) begin
              rank_flat[r*IDX_W +: IDX_W] <= pick_s + IDX_W'(1);
            end
          end
          for (int k = 0; k < NUM_SYM; k++) begin
            if (pick_s == IDX_W'(k)) begin
              picked_r[k] <= 1'b1;
            end
          end
          if (step_r == IDX_W'(NUM_SYM - 1)) begin
            // Last rank written: clear frame state and resume collecting.
            sort_valid   <= 1'b1;
            busy         <= 1'b0;
            sample_cnt_r <= '0;
            picked_r     <= '0;
            step_r       <= '0;
            state_r      <= ACC;
            for (int k = 0; k < NUM_SYM; k++) begin
              counts_r[k] <= '0;
            end
          end else begin
            step_r <= step_r + IDX_W'(1);
          end
        end
        default: begin
          state_r <= ACC;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef HUFF_OOR_CNT_EN
  logic [CNT_W-1:0] oor_cnt_r;

  // Saturating count of out-of-range samples while collecting, per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_cnt_r <= '0;
    end else if ((state_r == SORT) && (step_r == IDX_W'(NUM_SYM - 1))) begin
      oor_cnt_r <= '0;
    end else if (gray_valid && !in_range_s && (state_r == ACC) && (oor_cnt_r != '1)) begin
      oor_cnt_r <= oor_cnt_r + CNT_W'(1);
    end
  end

  assign oor_cnt = oor_cnt_r;
`else
  assign oor_cnt = '0;
`endif

endmodule

// File: tb/tb_huffman_rank.sv
// tb_huffman_rank -- directed sequence of randomized frames for huffman_rank
// with default parameters, checked against a reference histogram/rank model.
module tb_huffman_rank;

  localparam int NS  = 6;
  localparam int DW  = 8;
  localparam int TOT = 100;
  localparam int CW  = 8;
  localparam int IW  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              gray_valid;
  logic [DW-1:0]     gray_data;
  logic              busy;
  logic              CNT_valid;
  logic [NS*CW-1:0]  cnt_flat;
  logic              sort_valid;
  logic [NS*IW-1:0]  rank_flat;
  logic [CW-1:0]     oor_cnt;

  int checks = 0;
  int errors = 0;
  int stim_q[$];

  huffman_rank dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .busy       (busy),
    .CNT_valid  (CNT_valid),
    .cnt_flat   (cnt_flat),
    .sort_valid (sort_valid),
    .rank_flat  (rank_flat),
    .oor_cnt    (oor_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame stimulus: in-range symbols per count vector, shuffled, plus
  // out-of-range and idle entries (-1) inserted anywhere before the last sample.
  task automatic build_frame(input int c[NS], input int n_oor, input int n_idle);
    int tmp;
    int j;
    int v;
    stim_q.delete();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < c[s]; n++) stim_q.push_back(s + 1);
    for (int i = stim_q.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = stim_q[i]; stim_q[i] = stim_q[j]; stim_q[j] = tmp;
    end
    for (int i = 0; i < n_oor; i++) begin
      v = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 9 : int'($urandom_range(255, NS + 1));
      stim_q.insert(int'($urandom_range(stim_q.size() - 1, 0)), v);
    end
    for (int i = 0; i < n_idle; i++)
      stim_q.insert(int'($urandom_range(stim_q.size() - 1, 0)), -1);
  endtask

  task automatic random_counts(output int c[NS]);
    for (int s = 0; s < NS; s++) c[s] = 0;
    for (int n = 0; n < TOT; n++) c[$urandom_range(NS - 1, 0)]++;
  endtask

  // Drives the built frame, then follows the ranking phase cycle by cycle.
  task automatic run_frame(input bit hold2, input int rst_at);
    int ref_cnt[NS];
    int ref_oor = 0;
    int acc = 0;
    int rnk;
    bit early_bad = 1'b0;
    logic [NS*CW-1:0] exp_cnt;
    logic [NS*IW-1:0] exp_rank;
    logic [CW-1:0]    exp_oor;
    for (int s = 0; s < NS; s++) ref_cnt[s] = 0;
    foreach (stim_q[i]) begin
      if (stim_q[i] < 0) begin
        gray_valid = 1'b0;
        gray_data  = DW'($urandom);
      end else begin
        gray_valid = 1'b1;
        gray_data  = DW'(stim_q[i]);
        if (stim_q[i] >= 1 && stim_q[i] <= NS) begin
          ref_cnt[stim_q[i] - 1]++;
          acc++;
        end else if (ref_oor < 255) begin
          ref_oor++;
        end
      end
      tick();
      if (acc < TOT && (CNT_valid !== 1'b0 || busy !== 1'b0 || sort_valid !== 1'b0))
        early_bad = 1'b1;
    end
    gray_valid = 1'b0;
    check("frame_quiet", 64'(early_bad), 64'd0);

    // Reference histogram and stable descending ranking.
    for (int s = 0; s < NS; s++) begin
      exp_cnt[s*CW +: CW] = CW'(ref_cnt[s]);
      rnk = 0;
      for (int t = 0; t < NS; t++)
        if (ref_cnt[t] > ref_cnt[s] || (ref_cnt[t] == ref_cnt[s] && t < s)) rnk++;
      exp_rank[rnk*IW +: IW] = IW'(s + 1);
    end
`ifdef HUFF_OOR_CNT_EN
    exp_oor = CW'(ref_oor);
`else
    exp_oor = '0;
`endif

    check("cnt_valid", 64'(CNT_valid), 64'd1);
    check("busy_sort", 64'(busy), 64'd1);
    check("cnt_flat", 64'(cnt_flat), 64'(exp_cnt));
    check("oor_cnt", 64'(oor_cnt), 64'(exp_oor));

    for (int i = 1; i <= NS; i++) begin
      if (rst_at == i) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt_valid", 64'(CNT_valid), 64'd0);
        check("rst_sort_valid", 64'(sort_valid), 64'd0);
        check("rst_cnt_flat", 64'(cnt_flat), 64'd0);
        check("rst_rank_flat", 64'(rank_flat), 64'd0);
        check("rst_oor", 64'(oor_cnt), 64'd0);
        return;
      end
      if (i > 1) begin
        check("sort_busy", 64'(busy), 64'd1);
        check("sort_no_valid", 64'({CNT_valid, sort_valid}), 64'd0);
      end
      gray_valid = hold2;
      gray_data  = DW'(2);
      tick();
    end
    gray_valid = 1'b0;
    check("sort_valid", 64'(sort_valid), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("cnt_valid_low", 64'(CNT_valid), 64'd0);
    check("rank_flat", 64'(rank_flat), 64'(exp_rank));
    check("cnt_hold", 64'(cnt_flat), 64'(exp_cnt));
    check("oor_clear", 64'(oor_cnt), 64'd0);
    tick();
    check("sort_pulse", 64'(sort_valid), 64'd0);
    check("rank_hold", 64'(rank_flat), 64'(exp_rank));
  endtask

  initial begin
    int c[NS];
    reset      = 1'b1;
    gray_valid = 1'b0;
    gray_data  = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_cnt_valid", 64'(CNT_valid), 64'd0);
    check("reset_sort_valid", 64'(sort_valid), 64'd0);
    check("reset_cnt_flat", 64'(cnt_flat), 64'd0);
    check("reset_rank_flat", 64'(rank_flat), 64'd0);
    check("reset_oor", 64'(oor_cnt), 64'd0);

    // Distinct counts with one tie between symbols 4 and 5.
    c = '{30, 25, 20, 10, 10, 5};
    build_frame(c, 0, 0);
    run_frame(1'b0, 0);

    // Single symbol; zero-count symbols ranked by ID.
    c = '{0, 0, 100, 0, 0, 0};
    build_frame(c, 0, 5);
    run_frame(1'b0, 0);

    // Out-of-range samples interleaved, symbol 2 held during ranking.
    random_counts(c);
    build_frame(c, 7, 4);
    run_frame(1'b1, 0);

    // Next frame must start from an empty histogram.
    random_counts(c);
    build_frame(c, 3, 3);
    run_frame(1'b0, 0);

    // Reset in the third ranking cycle, then a fresh frame.
    random_counts(c);
    build_frame(c, 2, 0);
    run_frame(1'b0, 3);
    random_counts(c);
    build_frame(c, 0, 6);
    run_frame(1'b0, 0);

    // Enough out-of-range samples to saturate the counter.
    random_counts(c);
    build_frame(c, 260, 2);
    run_frame(1'b0, 0);

    repeat (2) begin
      random_counts(c);
      build_frame(c, int'($urandom_range(5, 0)), int'($urandom_range(5, 0)));
      run_frame(1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
